// File: rtl/pc_pkg.sv
// Shared widths, PC type and offset helper for the fetch-stage program counter.
package pc_pkg;

    localparam int unsigned PC_W             = 32;
    localparam int unsigned IMM_W            = 16;
    localparam int unsigned JMP_W            = 26;
    localparam int unsigned INC_STEP_DEFAULT = 4;

    typedef logic [PC_W-1:0] pc_t;

    // Sign-extend a word offset to PC width and convert it to a byte offset.
    function automatic pc_t sext_word_off(input logic [JMP_W-1:0] off);
        return pc_t'({{(PC_W-JMP_W){off[JMP_W-1]}}, off} << 2);
    endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection: register load, sequential step or relative offset.
// Word alignment of the result is applied when PC_ALIGN_EN is defined.
module pc_next
    import pc_pkg::*;
#(
    parameter int unsigned INC_STEP = INC_STEP_DEFAULT
) (
    input  logic             load_new_PC,
    input  logic             sel_inc,
    input  pc_t              pc_val,
    input  pc_t              RS1_val,
    input  logic [IMM_W-1:0] immediate,
    input  logic [JMP_W-1:0] value,
    output pc_t              next_pc_c
);

    pc_t imm_off_c;
    pc_t jmp_off_c;
    pc_t raw_c;

    // Branch field is widened to the jump width first so one helper serves both.
    assign imm_off_c = sext_word_off({{(JMP_W-IMM_W){immediate[IMM_W-1]}}, immediate});
    assign jmp_off_c = sext_word_off(value);

    always_comb begin
        raw_c = pc_val + PC_W'(INC_STEP);
        if (load_new_PC) begin
            raw_c = RS1_val;
        end else if (!sel_inc) begin
            raw_c = pc_val + imm_off_c + jmp_off_c;
        end
    end

`ifdef PC_ALIGN_EN
    assign next_pc_c = {raw_c[PC_W-1:2], 2'b00};
`else
    assign next_pc_c = raw_c;
`endif

endmodule

// File: rtl/program_counter.sv
// Fetch-stage program counter register with async reset and stall (enable).
// Optional build macro PC_ALIGN_EN forces every new PC value to word alignment.
module program_counter
    import pc_pkg::*;
#(
    parameter pc_t         RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned INC_STEP     = INC_STEP_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable_PC,
    input  logic             load_new_PC,
    input  logic             sel_inc,
    input  pc_t              RS1_val,
    input  logic [IMM_W-1:0] immediate,
    input  logic [JMP_W-1:0] value,
    output pc_t              pc_val
);

    pc_t next_pc_c;

    pc_next #(
        .INC_STEP (INC_STEP)
    ) u_pc_next (
        .load_new_PC (load_new_PC),
        .sel_inc     (sel_inc),
        .pc_val      (pc_val),
        .RS1_val     (RS1_val),
        .immediate   (immediate),
        .value       (value),
        .next_pc_c   (next_pc_c)
    );

    // PC register; a low enable stalls fetch by holding the current address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_val <= RESET_VECTOR;
        end else if (enable_PC) begin
            pc_val <= next_pc_c;
        end
    end

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed plan steps, then randomized
// control/offset traffic compared against an arithmetic reference model.
module tb_program_counter;

    logic        clk;
    logic        reset_n;
    logic        enable_PC;
    logic        load_new_PC;
    logic        sel_inc;
    logic [31:0] RS1_val;
    logic [15:0] immediate;
    logic [25:0] value;
    logic [31:0] pc_val;

    int unsigned passed;
    int unsigned failed;
    int unsigned total;
    logic [31:0] exp_pc;

`ifdef PC_ALIGN_EN
    localparam logic [31:0] LOAD_EXP = 32'hDEAD_BEEC;
    localparam logic [31:0] STEP_EXP = 32'hDEAD_BEF0;
`else
    localparam logic [31:0] LOAD_EXP = 32'hDEAD_BEEF;
    localparam logic [31:0] STEP_EXP = 32'hDEAD_BEF3;
`endif

    program_counter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable_PC   (enable_PC),
        .load_new_PC (load_new_PC),
        .sel_inc     (sel_inc),
        .RS1_val     (RS1_val),
        .immediate   (immediate),
        .value       (value),
        .pc_val      (pc_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: next PC from the operation rules, using signed integer word arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic en,
                                               input logic ld, input logic inc,
                                               input logic [31:0] rs1,
                                               input logic [15:0] imm,
                                               input logic [25:0] val);
        int          off_words;
        logic [31:0] n;
        if (!en) return cur;
        if (ld) begin
            n = rs1;
        end else if (inc) begin
            n = cur + 32'd4;
        end else begin
            off_words = int'($signed(imm)) + int'($signed(val));
            n = cur + 32'(off_words * 4);
        end
`ifdef PC_ALIGN_EN
        n[1:0] = 2'b00;
`endif
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge: advance the model with the inputs present at the edge, then compare.
    task automatic tick(input string tag);
        logic [31:0] nxt;
        nxt = model_next(exp_pc, enable_PC, load_new_PC, sel_inc, RS1_val, immediate, value);
        @(posedge clk);
        #1;
        if (reset_n) exp_pc = nxt;
        check(tag, pc_val, exp_pc);
    endtask

    task automatic set_ctrl(input logic en, input logic ld, input logic inc);
        enable_PC   = en;
        load_new_PC = ld;
        sel_inc     = inc;
    endtask

    initial begin
        passed = 0;
        failed = 0;
        total  = 0;
        exp_pc = 32'h0;

        reset_n   = 1'b0;
        set_ctrl(1'b1, 1'b0, 1'b1);
        RS1_val   = 32'h0;
        immediate = 16'h0;
        value     = 26'h0;

        // Reset is visible before any clock edge and holds across edges.
        #2;
        check("reset_pre_edge", pc_val, 32'h0);
        tick("reset_hold_1");
        tick("reset_hold_2");
        check("reset_const", pc_val, 32'h0);

        reset_n = 1'b1;
        tick("inc_1");
        check("inc_1_const", pc_val, 32'h4);
        tick("inc_2");
        tick("inc_3");
        tick("inc_4");
        check("inc_4_const", pc_val, 32'h10);

        set_ctrl(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick("stall");
        check("stall_const", pc_val, 32'h10);
        set_ctrl(1'b1, 1'b0, 1'b1);
        tick("reenable");
        check("reenable_const", pc_val, 32'h14);

        set_ctrl(1'b1, 1'b1, 1'b0);
        RS1_val = 32'h10;
        tick("load_0x10");
        set_ctrl(1'b1, 1'b0, 1'b0);
        immediate = 16'hDEAD;
        value     = 26'h0;
        tick("branch_neg");
        check("branch_neg_const", pc_val, 32'hFFFF_7AC4);
        immediate = 16'h0;
        value     = 26'h1;
        tick("jump_pos");
        check("jump_pos_const", pc_val, 32'hFFFF_7AC8);

        set_ctrl(1'b1, 1'b1, 1'b1);
        RS1_val = 32'hDEAD_BEEF;
        tick("load_over_inc");
        check("load_const", pc_val, LOAD_EXP);
        set_ctrl(1'b1, 1'b0, 1'b1);
        tick("inc_after_load");
        check("inc_after_load_const", pc_val, STEP_EXP);

        // Asynchronous reset between edges.
        #3;
        reset_n = 1'b0;
        #1;
        exp_pc = 32'h0;
        check("async_reset", pc_val, 32'h0);
        tick("async_reset_edge");
        reset_n = 1'b1;

        set_ctrl(1'b1, 1'b1, 1'b0);
        RS1_val = 32'hFFFF_FFFC;
        tick("load_top");
        set_ctrl(1'b1, 1'b0, 1'b1);
        tick("wrap");
        check("wrap_const", pc_val, 32'h0);

        // Randomized traffic, with occasional mid-cycle reset pulses.
        for (int i = 0; i < 400; i++) begin
            enable_PC   = ($urandom_range(0, 4) != 0);
            load_new_PC = ($urandom_range(0, 5) == 0);
            sel_inc     = ($urandom_range(0, 1) == 0);
            RS1_val     = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                immediate = 16'($urandom);
                value     = 26'h0;
            end else begin
                immediate = 16'h0;
                value     = 26'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                immediate = 16'($urandom);
                value     = 26'($urandom);
            end
            tick("random");
            if ($urandom_range(0, 39) == 0) begin
                #2;
                reset_n = 1'b0;
                #1;
                exp_pc = 32'h0;
                check("random_async_reset", pc_val, 32'h0);
                tick("random_reset_edge");
                reset_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
